// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side consumer.
// Buffer depth, pointer type and wrapping increment.
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 3;

  typedef logic [1:0] ptr_t;
  typedef logic [1:0] occ_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry circular store between FIFO and stream.
// Tracks head, tail and occupancy; flush empties it.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  ptr_t                  head;
  ptr_t                  tail;

  assign rdata = mem[head];

  // Storage is data-only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[tail] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        tail <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_fwft_reader.sv
// Standard-read FIFO drain presented as a FWFT stream.
// Credit = occupancy + in-flight beat, capped at depth.
module fifo_fwft_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_empty,
  output logic                   o_rd_en,
  input  logic [DATA_WIDTH-1:0]  i_rd_data,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  input  logic                   i_flush,
  output logic [COUNT_WIDTH-1:0] o_count
);

  logic       inflight;
  logic       discard;
  logic       push;
  logic       pop;
  occ_t       occ;
  logic [2:0] credit;

  // Credits never look at i_ready, keeping rd_en off the
  // downstream combinational path.
  assign credit  = {1'b0, occ} + {2'b00, inflight};
  assign o_rd_en = i_rst_n && !i_empty && !i_flush
                && (credit < 3'(BUF_DEPTH));

  assign o_valid = (occ != '0);
  assign push    = inflight && !discard;
  assign pop     = o_valid && i_ready;

  fifo_rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .pop   (pop),
    .flush (i_flush),
    .wdata (i_rd_data),
    .rdata (o_data),
    .occ   (occ)
  );

  // Track the beat the FIFO returns next cycle, and
  // mark it for dropping if a flush overtakes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else begin
      inflight <= o_rd_en;
      discard  <= i_flush && inflight;
    end
  end

  // Count accepted beats; a flush cancels the handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
    end else if (pop && !i_flush) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule
